// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux16_rr_arbiter
// Brief   : 16-way round-robin arbiter feeding a registered-select 16:1 mux
//           with a valid/ready output. Optional macro: MUX_ARB_BURST_EN.
// Revision: 1.0  initial release
// ============================================================================
module mux16_rr_arbiter #(
    parameter int DATA_W    = 6,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            req,
    input  logic [16*DATA_W-1:0]   datain_flat,
    output logic [15:0]            ack,
    output logic [3:0]             select,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  select_q, select_d;
    logic [3:0]  last_grant_q, last_grant_d;
    logic        w_xfer;
    logic [15:0] w_arb_mask;
    logic [3:0]  w_arb_base;
    logic [3:0]  w_winner;
    logic        w_winner_found;
    logic [3:0]  w_idx;

`ifdef MUX_ARB_BURST_EN
    localparam logic [4:0] C_BURST_MAX = 5'(BURST_LEN - 1);
    logic [4:0]  burst_cnt_q, burst_cnt_d;
`endif

    assign out_valid = (state_q == SEND);
    assign select    = select_q;
    assign out_data  = out_valid ? datain_flat[int'(select_q)*DATA_W +: DATA_W] : '0;
    // A reset cycle never acknowledges: the in-flight word is dropped.
    assign w_xfer    = out_valid && out_ready && !reset;

    always_comb begin
        ack = '0;
        if (w_xfer) begin
            ack[select_q] = 1'b1;
        end
    end

    // On a transfer the current grant is excluded and scanning starts after it.
    always_comb begin
        if (state_q == SEND) begin
            w_arb_mask = req & ~(16'd1 << select_q);
            w_arb_base = select_q;
        end else begin
            w_arb_mask = req;
            w_arb_base = last_grant_q;
        end
    end

    always_comb begin
        w_winner       = '0;
        w_winner_found = 1'b0;
        w_idx          = '0;
        for (int k = 1; k <= 16; k++) begin
            w_idx = w_arb_base + 4'(k);
            if (!w_winner_found && w_arb_mask[w_idx]) begin
                w_winner       = w_idx;
                w_winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        last_grant_d = last_grant_q;
`ifdef MUX_ARB_BURST_EN
        burst_cnt_d  = burst_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_winner_found) begin
                    select_d = w_winner;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (w_xfer) begin
                    last_grant_d = select_q;
`ifdef MUX_ARB_BURST_EN
                    if (req[select_q] && (burst_cnt_q < C_BURST_MAX)) begin
                        burst_cnt_d = burst_cnt_q + 5'd1;
                    end else begin
                        burst_cnt_d = '0;
                        if (w_winner_found) begin
                            select_d = w_winner;
                        end else begin
                            state_d = IDLE;
                        end
                    end
`else
                    if (w_winner_found) begin
                        select_d = w_winner;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            select_q     <= 4'd0;
            last_grant_q <= 4'd15;
`ifdef MUX_ARB_BURST_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            last_grant_q <= last_grant_d;
`ifdef MUX_ARB_BURST_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

endmodule
`default_nettype wire
